dual_slope_controller: RTL and testbench

//  Dual-slope integrating ADC sequencer for the voltmeter. Consumes the sanitized comparator,

---
 rtl/dual_slope_if.sv | 33 +++
 rtl/dual_slope_controller.sv | 206 ++++++++++++++++++++
 tb/tb_dual_slope_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dual_slope_if.sv
// Front-end / result bundle of the dual-slope ADC sequencer.
// The controller attaches through the slave modport; the measurement side uses master.
interface dual_slope_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 start_i;
    logic                 comp_i;
    logic                 sat_hi_i;
    logic                 sat_lo_i;
    logic                 ref_ok_i;
    logic                 sw_az_o;
    logic                 sw_in_o;
    logic                 sw_refp_o;
    logic                 sw_refn_o;
    logic                 busy_o;
    logic [CNT_WIDTH-1:0] result_o;
    logic                 polarity_o;
    logic                 valid_o;
    logic                 ovr_o;
    logic                 err_o;

    modport slave (
        input  start_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
        output sw_az_o, sw_in_o, sw_refp_o, sw_refn_o, busy_o,
        output result_o, polarity_o, valid_o, ovr_o, err_o
    );

    modport master (
        output start_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
        input  sw_az_o, sw_in_o, sw_refp_o, sw_refn_o, busy_o,
        input  result_o, polarity_o, valid_o, ovr_o, err_o
    );
endinterface

// File: rtl/dual_slope_controller.sv
// Dual-slope integrating ADC sequencer: auto-zero, fixed integrate, reference de-integrate.
// Define DUAL_SLOPE_AUTORUN_EN for continuous conversion (start_i ignored).
module dual_slope_controller #(
    parameter int CNT_WIDTH   = 16,
    parameter int T_AZ        = 1000,
    parameter int T_INT       = 10000,
    parameter int T_DEINT_MAX = 20000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dual_slope_if.slave bus
);
    localparam int TMR_MAX = (T_AZ > T_INT) ? T_AZ : T_INT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]     AZ_LAST  = TMR_W'(T_AZ - 1);
    localparam logic [TMR_W-1:0]     INT_LAST = TMR_W'(T_INT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(T_DEINT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE, AUTOZERO, GAP1, INTEGRATE, GAP2, DEINT, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 pol_q, pol_d;
    logic [CNT_WIDTH-1:0] pendRes_q, pendRes_d;
    logic                 pendOvr_q, pendOvr_d;
    logic                 pendErr_q, pendErr_d;

    logic                 swAz_q, swIn_q, swRefp_q, swRefn_q, busy_q;
    logic [CNT_WIDTH-1:0] result_q;
    logic                 polarity_q, valid_q, ovr_q, err_q;

    logic busyState;
    logic satAny;

    assign busyState = state_q inside {AUTOZERO, GAP1, INTEGRATE, GAP2, DEINT};
    assign satAny    = bus.sat_hi_i | bus.sat_lo_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            pol_q     <= 1'b0;
            pendRes_q <= '0;
            pendOvr_q <= 1'b0;
            pendErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            pol_q     <= pol_d;
            pendRes_q <= pendRes_d;
            pendOvr_q <= pendOvr_d;
            pendErr_q <= pendErr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        count_d   = count_q;
        pol_d     = pol_q;
        pendRes_d = pendRes_q;
        pendOvr_d = pendOvr_q;
        pendErr_d = pendErr_q;

        case (state_q)
            IDLE: begin
`ifdef DUAL_SLOPE_AUTORUN_EN
                if (bus.ref_ok_i) begin
                    state_d = AUTOZERO;
                    timer_d = '0;
                    pol_d   = 1'b0;
                end
`else
                if (bus.start_i) begin
                    pol_d = 1'b0;
                    if (bus.ref_ok_i) begin
                        state_d = AUTOZERO;
                        timer_d = '0;
                    end else begin
                        state_d   = DONE;
                        pendRes_d = '0;
                        pendOvr_d = 1'b0;
                        pendErr_d = 1'b1;
                    end
                end
`endif
            end
            AUTOZERO: begin
                if (timer_q == AZ_LAST) state_d = GAP1;
                else                    timer_d = timer_q + 1'b1;
            end
            GAP1: begin
                state_d = INTEGRATE;
                timer_d = '0;
            end
            INTEGRATE: begin
                // Sign of the integrated input is what the comparator shows at the very end.
                if (timer_q == INT_LAST) begin
                    state_d = GAP2;
                    pol_d   = bus.comp_i;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP2: begin
                state_d = DEINT;
                count_d = '0;
            end
            DEINT: begin
                if (bus.comp_i == pol_q) begin
                    if (count_q == CNT_LAST) begin
                        count_d   = count_q + 1'b1;
                        state_d   = DONE;
                        pendRes_d = '1;
                        pendOvr_d = 1'b1;
                        pendErr_d = 1'b0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    state_d   = DONE;
                    pendRes_d = count_q;
                    pendOvr_d = 1'b0;
                    pendErr_d = 1'b0;
                end
            end
            DONE: begin
`ifdef DUAL_SLOPE_AUTORUN_EN
                if (bus.ref_ok_i) begin
                    state_d = AUTOZERO;
                    timer_d = '0;
                    pol_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // A reference fault outranks saturation when both appear in the same cycle.
        if (busyState && !bus.ref_ok_i) begin
            state_d   = DONE;
            pendRes_d = '0;
            pendOvr_d = 1'b0;
            pendErr_d = 1'b1;
        end else if ((state_q == INTEGRATE || state_q == DEINT) && satAny) begin
            state_d   = DONE;
            pendRes_d = '1;
            pendOvr_d = 1'b1;
            pendErr_d = 1'b0;
        end
    end

    // Outputs decode the current state one register stage later, so switch edges are glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            swAz_q     <= 1'b0;
            swIn_q     <= 1'b0;
            swRefp_q   <= 1'b0;
            swRefn_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            polarity_q <= 1'b0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            swAz_q   <= (state_q == AUTOZERO);
            swIn_q   <= (state_q == INTEGRATE);
            swRefp_q <= (state_q == DEINT) && !pol_q;
            swRefn_q <= (state_q == DEINT) && pol_q;
            busy_q   <= busyState;
            valid_q  <= (state_q == DONE);
            if (state_q == DONE) begin
                result_q   <= pendRes_q;
                polarity_q <= pol_q;
                ovr_q      <= pendOvr_q;
                err_q      <= pendErr_q;
            end
`ifdef DUAL_SLOPE_AUTORUN_EN
            else if (state_q == IDLE && !bus.ref_ok_i) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.sw_az_o    = swAz_q;
    assign bus.sw_in_o    = swIn_q;
    assign bus.sw_refp_o  = swRefp_q;
    assign bus.sw_refn_o  = swRefn_q;
    assign bus.busy_o     = busy_q;
    assign bus.valid_o    = valid_q;
    assign bus.result_o   = result_q;
    assign bus.polarity_o = polarity_q;
    assign bus.ovr_o      = ovr_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_dual_slope_controller.sv
// Directed bench for dual_slope_controller with T_AZ=4, T_INT=16, T_DEINT_MAX=40, CNT_WIDTH=8.
// Edge 0 is the clock edge that samples start_i; all expected edge numbers count from it.
module tb_dual_slope_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    int validEdge, azCnt, inCnt, refpCnt, refnCnt, busyCnt, hazardCnt, validAfter;
    int obsResult, obsPol, obsOvr, obsErr;

    dual_slope_if #(.CNT_WIDTH(8)) bus ();

    dual_slope_controller #(
        .CNT_WIDTH  (8),
        .T_AZ       (4),
        .T_INT      (16),
        .T_DEINT_MAX(40)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One conversion; inputs for edge e are driven on the negedge before it.
    task automatic applyStimulus(input bit compInt, input int nDeint, input bit refAtStart,
                                 input int satHiEdge, input int satLoEdge, input int refDropEdge,
                                 input int extraStartEdge);
        logic [3:0] curSw;
        logic [3:0] prevSw;
        bit seen;
        validEdge = -1; azCnt = 0; inCnt = 0; refpCnt = 0; refnCnt = 0;
        busyCnt = 0; hazardCnt = 0; validAfter = -1;
        prevSw = '0;
        seen = 1'b0;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.ref_ok_i = refAtStart;
        bus.comp_i   = compInt;
        bus.sat_hi_i = 1'b0;
        bus.sat_lo_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 120 && !seen; k++) begin
            int e;
            curSw = {bus.sw_az_o, bus.sw_in_o, bus.sw_refp_o, bus.sw_refn_o};
            if ($countones(curSw) > 1 || (prevSw != 0 && curSw != 0 && curSw != prevSw)) hazardCnt++;
            prevSw = curSw;
            azCnt   += int'(bus.sw_az_o);
            inCnt   += int'(bus.sw_in_o);
            refpCnt += int'(bus.sw_refp_o);
            refnCnt += int'(bus.sw_refn_o);
            busyCnt += int'(bus.busy_o);
            if (bus.valid_o) begin
                seen      = 1'b1;
                validEdge = k;
                obsResult = int'(bus.result_o);
                obsPol    = int'(bus.polarity_o);
                obsOvr    = int'(bus.ovr_o);
                obsErr    = int'(bus.err_o);
            end
            e = k + 1;
            bus.start_i  = (e == extraStartEdge);
            bus.comp_i   = (e <= 22 + nDeint) ? compInt : ~compInt;
            bus.sat_hi_i = (e == satHiEdge);
            bus.sat_lo_i = (e == satLoEdge);
            bus.ref_ok_i = (e != refDropEdge);
            if (!seen) @(negedge clk);
        end
        bus.start_i  = 1'b0;
        bus.comp_i   = 1'b0;
        bus.sat_hi_i = 1'b0;
        bus.sat_lo_i = 1'b0;
        bus.ref_ok_i = 1'b1;
        if (seen) begin
            @(negedge clk);
            validAfter = int'(bus.valid_o);
        end
    endtask

    task automatic expectRun(input string name, input int vEdge, input int res, input int pol,
                             input int ovr, input int err, input int az, input int inn,
                             input int refp, input int refn, input int busy);
        checkOutput({name, "_validEdge"}, validEdge, vEdge);
        checkOutput({name, "_validPulse"}, validAfter, 0);
        checkOutput({name, "_result"}, obsResult, res);
        if (pol >= 0) checkOutput({name, "_polarity"}, obsPol, pol);
        checkOutput({name, "_ovr"}, obsOvr, ovr);
        checkOutput({name, "_err"}, obsErr, err);
        checkOutput({name, "_swAz"}, azCnt, az);
        checkOutput({name, "_swIn"}, inCnt, inn);
        checkOutput({name, "_swRefp"}, refpCnt, refp);
        checkOutput({name, "_swRefn"}, refnCnt, refn);
        checkOutput({name, "_busy"}, busyCnt, busy);
        checkOutput({name, "_hazard"}, hazardCnt, 0);
    endtask

    function automatic logic [31:0] outVec();
        return {bus.sw_az_o, bus.sw_in_o, bus.sw_refp_o, bus.sw_refn_o, bus.busy_o,
                bus.valid_o, bus.polarity_o, bus.ovr_o, bus.err_o, bus.result_o};
    endfunction

    initial begin
        bus.start_i  = 1'b0;
        bus.comp_i   = 1'b0;
        bus.sat_hi_i = 1'b0;
        bus.sat_lo_i = 1'b0;
        bus.ref_ok_i = 1'b1;
        #2 rst = 1'b1;
        #2;
        checkOutput("reset_async", outVec(), 0);
        repeat (2) @(negedge clk);
        checkOutput("reset_held", outVec(), 0);
        rst = 1'b0;

`ifdef DUAL_SLOPE_AUTORUN_EN
        begin : autorunRuns
            int vEdges[2];
            int vRes[2];
            int nV;
            nV = 0;
            vEdges[0] = -1; vEdges[1] = -1;
            vRes[0] = -1;   vRes[1] = -1;
            bus.comp_i = 1'b1;
            for (int k = 0; k < 100 && nV < 2; k++) begin
                @(negedge clk);
                if (bus.valid_o) begin
                    vEdges[nV] = k;
                    vRes[nV]   = int'(bus.result_o);
                    nV++;
                end
                bus.comp_i = (((k + 1) % 34) <= 32);
            end
            checkOutput("auto_firstValid", vEdges[0], 34);
            checkOutput("auto_secondValid", vEdges[1], 68);
            checkOutput("auto_firstResult", vRes[0], 10);
            checkOutput("auto_secondResult", vRes[1], 10);
        end
`else
        // Positive input, crossing after 10 counts; a stray start mid-conversion is ignored.
        applyStimulus(1'b1, 10, 1'b1, 0, 0, 0, 15);
        expectRun("pos10", 34, 10, 1, 0, 0, 4, 16, 0, 11, 33);
        repeat (5) @(negedge clk);
        checkOutput("pos10_resultHeld", int'(bus.result_o), 10);
        checkOutput("pos10_busyIdle", int'(bus.busy_o), 0);

        applyStimulus(1'b0, 25, 1'b1, 0, 0, 0, 0);
        expectRun("neg25", 49, 25, 0, 0, 0, 4, 16, 26, 0, 48);

        applyStimulus(1'b1, 1000, 1'b1, 0, 0, 0, 0);
        expectRun("timeout", 63, 255, -1, 1, 0, 4, 16, 0, 40, 62);

        applyStimulus(1'b1, 1000, 1'b1, 10, 0, 0, 0);
        expectRun("satHiInt", 11, 255, -1, 1, 0, 4, 5, 0, 0, 10);

        applyStimulus(1'b0, 1000, 1'b1, 0, 27, 0, 0);
        expectRun("satLoDeint", 28, 255, -1, 1, 0, 4, 16, 5, 0, 27);

        applyStimulus(1'b1, 10, 1'b0, 0, 0, 0, 0);
        expectRun("refIdle", 1, 0, -1, 0, 1, 0, 0, 0, 0, 0);

        applyStimulus(1'b1, 1000, 1'b1, 30, 0, 30, 0);
        expectRun("refAndSat", 31, 0, -1, 0, 1, 4, 16, 0, 8, 30);

        // Reset asserted between edges in the middle of integration.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.comp_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("rst_preSwIn", int'(bus.sw_in_o), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_midInt", outVec(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_staysIdle", outVec(), 0);

        applyStimulus(1'b0, 25, 1'b1, 0, 0, 0, 0);
        expectRun("afterRst", 49, 25, 0, 0, 0, 4, 16, 26, 0, 48);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
